// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: a gate-driven five-state FSM produces a UQ0.ENV_BITS
// level that scales the oscillator sample stream, advancing only on the sample strobe.
module adsr_envelope #(
    parameter int WIDTH    = 16,
    parameter int ENV_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                gate,
    input  logic [ENV_BITS-1:0] attack_rate,
    input  logic [ENV_BITS-1:0] decay_rate,
    input  logic [ENV_BITS-1:0] sustain_level,
    input  logic [ENV_BITS-1:0] release_rate,
    input  logic [WIDTH-1:0]    in,
    output logic [WIDTH-1:0]    out,
    output logic [ENV_BITS-1:0] level,
    output logic                active
);

    localparam int                PW        = WIDTH + ENV_BITS + 1;
    localparam logic [ENV_BITS-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [ENV_BITS-1:0]   level_q, level_d;
    logic [WIDTH-1:0]      out_q, out_d;

    logic [ENV_BITS:0]          attack_sum;
    logic signed [ENV_BITS+1:0] decay_diff;
    logic signed [ENV_BITS+1:0] release_diff;
    logic signed [ENV_BITS+1:0] sustain_ext;
    logic signed [PW-1:0]       in_ext;
    logic signed [PW-1:0]       level_ext;
    logic signed [PW-1:0]       product;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        level_d = level_q;

        attack_sum   = {1'b0, level_q} + {1'b0, attack_rate};
        decay_diff   = $signed({2'b00, level_q}) - $signed({2'b00, decay_rate});
        release_diff = $signed({2'b00, level_q}) - $signed({2'b00, release_rate});
        sustain_ext  = $signed({2'b00, sustain_level});

        // Gate edges take priority; the level is deliberately left alone so retriggers are legato.
        if (!gate && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (gate && (state_q == IDLE || state_q == RELEASE)) begin
            state_d = ATTACK;
        end else begin
            case (state_q)
                ATTACK: begin
                    if (attack_sum >= {1'b0, LEVEL_MAX}) begin
                        level_d = LEVEL_MAX;
                        state_d = DECAY;
                    end else begin
                        level_d = attack_sum[ENV_BITS-1:0];
                    end
                end
                DECAY: begin
                    if (decay_diff <= sustain_ext) begin
                        level_d = sustain_level;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = decay_diff[ENV_BITS-1:0];
                    end
                end
                SUSTAIN: level_d = sustain_level;
                RELEASE: begin
                    if (release_diff <= 0) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = release_diff[ENV_BITS-1:0];
                    end
                end
                default: level_d = '0;
            endcase
        end
    end

    // Level is strictly below 1.0, so the arithmetic shift never overflows WIDTH bits.
    always_comb begin
        in_ext    = {{(PW-WIDTH){in[WIDTH-1]}}, in};
        level_ext = {{(PW-ENV_BITS){1'b0}}, level_q};
        product   = in_ext * level_ext;
        out_d     = WIDTH'(product >>> ENV_BITS);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            out_q   <= '0;
        end else if (enable) begin
            state_q <= state_d;
            level_q <= level_d;
            out_q   <= out_d;
        end
    end

    assign out    = out_q;
    assign level  = level_q;
    assign active = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: each task drives one scenario and checks
// level/out/active against hand-computed values.
module tb_adsr_envelope;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] attack_rate = '0;
    logic [15:0] decay_rate = '0;
    logic [15:0] sustain_level = '0;
    logic [15:0] release_rate = '0;
    logic [15:0] in = '0;
    logic [15:0] out;
    logic [15:0] level;
    logic        active;

    int vectors = 0;
    int miscompares = 0;

    adsr_envelope #(.WIDTH(16), .ENV_BITS(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .in            (in),
        .out           (out),
        .level         (level),
        .active        (active)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // One enable strobe; outputs are sampled 1ns after the capturing edge.
    task automatic tick();
        enable = 1'b1;
        @(posedge clock);
        #1;
        enable = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [15:0] exp_level,
                                input logic exp_active);
        vectors++;
        if (level !== exp_level) begin
            $display("FAIL %s level: got %h want %h", name, level, exp_level);
            miscompares++;
        end
        vectors++;
        if (active !== exp_active) begin
            $display("FAIL %s active: got %b want %b", name, active, exp_active);
            miscompares++;
        end
    endtask

    task automatic expect_out(input string name, input logic [15:0] exp_out);
        vectors++;
        if (out !== exp_out) begin
            $display("FAIL %s out: got %h want %h", name, out, exp_out);
            miscompares++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        expect_state("reset", 16'h0000, 1'b0);
        expect_out("reset", 16'h0000);
    endtask

    task automatic test_attack();
        logic [15:0] exp_lvl [4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        logic [15:0] exp_o   [4] = '{16'h0000, 16'h1FFF, 16'h3FFF, 16'h5FFF};
        attack_rate   = 16'h4000;
        decay_rate    = 16'h0000;
        sustain_level = 16'h8000;
        in            = 16'h7FFF;
        gate          = 1'b1;
        tick();
        expect_state("attack_enter", 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state($sformatf("attack_t%0d", i + 1), exp_lvl[i], 1'b1);
            expect_out($sformatf("attack_t%0d", i + 1), exp_o[i]);
            repeat (3) @(posedge clock);
            #1;
            expect_state($sformatf("attack_hold%0d", i + 1), exp_lvl[i], 1'b1);
        end
    endtask

    // DECAY with a zero rate parks at full scale, exposing the extreme scaling cases.
    task automatic test_scaling_full();
        in = 16'h7FFF;
        tick();
        expect_state("decay_zero_rate", 16'hFFFF, 1'b1);
        expect_out("scale_ffff_pos", 16'h7FFE);
        in = 16'h8000;
        tick();
        expect_state("decay_zero_rate2", 16'hFFFF, 1'b1);
        expect_out("scale_ffff_neg", 16'h8000);
    endtask

    task automatic test_decay();
        logic [15:0] exp_lvl;
        decay_rate = 16'h1000;
        in         = 16'h0000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_lvl = 16'hFFFF - 16'(k * 16'h1000);
            expect_state($sformatf("decay_step%0d", k), exp_lvl, 1'b1);
        end
        tick();
        expect_state("decay_snap", 16'h8000, 1'b1);
        in = 16'h1234;
        tick();
        expect_state("sustain_hold", 16'h8000, 1'b1);
        expect_out("scale_half", 16'h091A);
        sustain_level = 16'h6000;
        tick();
        expect_state("sustain_track", 16'h6000, 1'b1);
    endtask

    task automatic test_release();
        logic [15:0] exp_lvl [4] = '{16'h6000, 16'h4000, 16'h2000, 16'h0000};
        logic        exp_act [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        release_rate = 16'h2000;
        gate         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state($sformatf("release_t%0d", i), exp_lvl[i], exp_act[i]);
        end
        in = 16'h7FFF;
        tick();
        expect_state("idle_stay", 16'h0000, 1'b0);
        expect_out("scale_zero", 16'h0000);
    endtask

    task automatic test_retrigger();
        attack_rate  = 16'h4000;
        release_rate = 16'h2000;
        gate = 1'b1;
        tick();
        tick();
        tick();
        expect_state("retrig_attack", 16'h8000, 1'b1);
        gate = 1'b0;
        tick();
        expect_state("retrig_release_enter", 16'h8000, 1'b1);
        tick();
        tick();
        expect_state("retrig_release", 16'h4000, 1'b1);
        gate = 1'b1;
        tick();
        expect_state("retrig_legato", 16'h4000, 1'b1);
        tick();
        expect_state("retrig_continue", 16'h8000, 1'b1);
    endtask

    task automatic test_zero_rates();
        do_reset();
        attack_rate  = 16'h0000;
        release_rate = 16'h0000;
        gate = 1'b1;
        tick();
        expect_state("zero_attack_enter", 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state($sformatf("zero_attack_hold%0d", i), 16'h0000, 1'b1);
        end
        gate = 1'b0;
        tick();
        expect_state("zero_release", 16'h0000, 1'b1);
        tick();
        expect_state("zero_idle", 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid_attack();
        attack_rate = 16'h4000;
        in          = 16'h7FFF;
        gate        = 1'b1;
        tick();
        tick();
        attack_rate = 16'h0000;
        tick();
        expect_state("pre_reset", 16'h4000, 1'b1);
        expect_out("pre_reset", 16'h1FFF);
        #2;
        reset = 1'b1;
        #1;
        expect_state("async_reset", 16'h0000, 1'b0);
        expect_out("async_reset", 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        gate  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_scaling_full();
        test_decay();
        test_release();
        test_retrigger();
        test_zero_rates();
        test_reset_mid_attack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
